// File: rtl/fir_coef_loader.sv
// fir_coef_loader: streams a burst of NCOEFS coefficients into coefficient storage via a registered write port
// and keeps a running sum of the burst.
module fir_coef_loader #(
  parameter int WIDTH  = 8,
  parameter int NCOEFS = 300,
  parameter int ADDR_W = $clog2(NCOEFS),
  parameter int SUM_W  = WIDTH + $clog2(NCOEFS)
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [WIDTH-1:0]  coef_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [SUM_W-1:0]  coef_sum
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic acc, last;
  assign in_ready = state == LOAD && !abort;
  assign acc = in_valid && in_ready;
  assign last = cnt == ADDR_W'(NCOEFS - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clock)
    if (!nreset) begin
      state <= IDLE;
      cnt <= '0;
      coef_we <= 1'b0;
      coef_addr <= '0;
      coef_data <= '0;
      aborted <= 1'b0;
      coef_sum <= '0;
    end else begin
      coef_we <= acc;
      aborted <= 1'b0;
      if (acc) begin
        coef_addr <= cnt;
        coef_data <= in_data;
        coef_sum <= coef_sum + SUM_W'(in_data);
        cnt <= last ? cnt : cnt + 1'b1;
      end
      // the counter saturates on the final beat; start re-arms it
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          cnt <= '0;
          coef_sum <= '0;
        end
        LOAD: if (abort) begin
          state <= IDLE;
          aborted <= 1'b1;
        end else if (acc && last) state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: directed test-plan bursts plus random traffic against a burst-level reference model.
module tb_fir_coef_loader;
  localparam int N = 4;
  logic clk = 1'b0, nreset, start, abort, in_valid;
  logic [7:0] in_data, coef_data;
  logic in_ready, coef_we, busy, done, aborted;
  logic [1:0] coef_addr;
  logic [9:0] coef_sum;
  int n_chk = 0, n_err = 0;
  int ph = 0;
  logic [7:0] q[$];
  logic e_we = 0, e_ab = 0;
  logic [1:0] e_addr = 0;
  logic [7:0] e_data = 0;
  int e_sum = 0;

  fir_coef_loader #(.WIDTH(8), .NCOEFS(N)) dut (
    .clock(clk), .nreset(nreset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .done(done), .aborted(aborted), .coef_sum(coef_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ph: 0 idle, 1 collecting beats, 2 burst complete; q holds the beats of the current burst
  task automatic cycle(input logic s, input logic a, input logic v, input logic [7:0] d, input logic r);
    logic ok;
    int tot;
    start = s; abort = a; in_valid = v; in_data = d; nreset = r;
    #1 chk("in_ready", in_ready, ph == 1 && !a);
    @(posedge clk);
    ok = ph == 1 && !a && v;
    if (!r) begin
      ph = 0; q.delete();
      e_we = 0; e_ab = 0; e_addr = 0; e_data = 0; e_sum = 0;
    end else begin
      e_we = ok; e_ab = 0;
      if (ok) begin
        q.push_back(d);
        e_addr = 2'(q.size() - 1);
        e_data = d;
        tot = 0;
        foreach (q[i]) tot += int'(q[i]);
        e_sum = tot;
      end
      if (ph == 0) begin
        if (s) begin ph = 1; q.delete(); e_sum = 0; end
      end else if (ph == 1) begin
        if (a) begin ph = 0; e_ab = 1; end
        else if (ok && q.size() == N) ph = 2;
      end else ph = 0;
    end
    @(negedge clk);
    chk("coef_we", coef_we, e_we);
    chk("coef_addr", coef_addr, e_addr);
    chk("coef_data", coef_data, e_data);
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 2);
    chk("aborted", aborted, e_ab);
    chk("coef_sum", coef_sum, e_sum);
  endtask

  task automatic idle();         cycle(0, 0, 0, 8'h00, 1); endtask
  task automatic go();           cycle(1, 0, 0, 8'h00, 1); endtask
  task automatic beat(input logic [7:0] d); cycle(0, 0, 1, d, 1); endtask

  initial begin
    nreset = 0; start = 0; abort = 0; in_valid = 0; in_data = 0;
    @(negedge clk);
    cycle(0, 0, 0, 8'h00, 0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sum", coef_sum, 10'h000);
    // back-to-back burst
    go(); beat(8'h10); beat(8'h20); beat(8'h30); beat(8'h40);
    chk("done_last", done, 1'b1);
    chk("sum_a0", coef_sum, 10'h0A0);
    idle();
    chk("busy_after", busy, 1'b0);
    idle();
    // burst with a two-cycle gap
    go(); beat(8'h10); beat(8'h20); idle(); idle(); beat(8'h30); beat(8'h40); idle(); idle();
    // abort after two beats
    go(); beat(8'hFF); beat(8'hFF); cycle(0, 1, 1, 8'h55, 1);
    chk("aborted_pulse", aborted, 1'b1);
    idle();
    chk("sum_held", coef_sum, 10'h1FE);
    go();
    chk("sum_cleared", coef_sum, 10'h000);
    idle(); cycle(0, 1, 0, 8'h00, 1); idle();
    // source keeps valid high past the burst
    go();
    for (int i = 0; i < 10; i++) beat(8'h01);
    chk("sum_four", coef_sum, 10'h004);
    // start ignored in LOAD and in DONE
    go(); beat(8'h11); cycle(1, 0, 1, 8'h22, 1); beat(8'h33); beat(8'h44);
    cycle(1, 1, 1, 8'h99, 1); idle(); idle();
    // reset mid-burst, then a clean burst
    go(); beat(8'hA1); beat(8'hA2); cycle(0, 0, 1, 8'hA3, 0);
    chk("rst_mid_we", coef_we, 1'b0);
    go(); beat(8'h05); beat(8'h06); beat(8'h07); beat(8'h08); idle();
    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            8'($urandom), $urandom_range(0, 63) != 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Streaming coefficient writer for the FIR filter datapath. Accepts a burst of exactly NCOEFS fixed-point coefficients over a valid/ready stream and writes them, in order, into the filter's coefficient storage through a registered write port. This lets software or a host interface replace the coefficient set at run time instead of fixing it at elaboration. It also returns an unsigned running sum of the loaded coefficients for gain/normalisation checking.

## Interface
- WIDTH, 8, coefficient width in bits (Q-format fixed point, treated as unsigned here)
- NCOEFS, 300, number of coefficients per burst; must be ≥ 2
- ADDR_W, $clog2(NCOEFS), coefficient address width
- SUM_W, WIDTH+$clog2(NCOEFS), width of the running sum; the full sum never overflows
- clock  in  1  single clock; all logic on the rising edge
- nreset  in  1  synchronous, active-low reset
- start  in  1  begin a load burst; honoured only in IDLE
- abort  in  1  cancel the current burst; honoured only in LOAD
- in_valid  in  1  source has a coefficient on in_data
- in_data  in  WIDTH  coefficient value
- in_ready  out  1  loader accepts a beat this cycle
- coef_we  out  1  write strobe to coefficient storage (registered)
- coef_addr  out  ADDR_W  write address (registered)
- coef_data  out  WIDTH  write data (registered)
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse when all NCOEFS have been written
- aborted  out  1  one-cycle pulse when a burst is cancelled
- coef_sum  out  SUM_W  sum of the coefficients accepted in the current/last burst

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0. If start=1, go to LOAD and clear the beat counter and coef_sum. in_valid is ignored in IDLE.
- LOAD: in_ready = ~abort, which is combinational from state and abort. A beat is accepted when in_valid & in_ready.
  - On an accepted beat, in the next cycle: coef_we=1, coef_addr=counter, coef_data=in_data. Also coef_sum += in_data (zero-extended) and counter += 1.
  - If the accepted beat has counter == NCOEFS-1, go to DONE.
  - If abort=1, go to IDLE and pulse aborted. No beat is accepted that cycle, and writes already issued stand.
  - start in LOAD is ignored.
  - A gap cycle (in_valid=0) holds state; coef_we=0 for that cycle.
- DONE: done=1 and in_ready=0 for exactly one cycle, then IDLE. start and abort are ignored in DONE.
- coef_we is 0 in every cycle not immediately following an accepted beat.
- coef_addr and coef_data hold their last values when coef_we=0.
- coef_sum holds its value after done or aborted until the next start.
- The counter never wraps. NCOEFS beats end the burst, and extra source beats are not accepted.
- Reset (nreset=0 at any edge, including mid-burst): state=IDLE, counter=0. All outputs are 0: in_ready, coef_we, coef_addr, coef_data, busy, done, aborted, coef_sum. A partial burst is discarded without an aborted pulse.

## Timing
- start sampled at edge t → LOAD from t+1. in_ready is high in cycle t+1 if abort=0.
- Beat accepted at edge k → coef_we/addr/data valid in cycle k+1 (latency 1). coef_sum is updated in cycle k+1.
- Throughput: one coefficient per cycle. The minimum burst is NCOEFS cycles from the first accepted beat.
- Last beat accepted at edge k → cycle k+1 has the final write, state DONE, done=1, busy=1, and final coef_sum. Cycle k+2 is IDLE with busy=0.
- abort sampled at edge a in LOAD → aborted=1 and state IDLE in cycle a+1. in_ready was already 0 in cycle a.
- New start is accepted at the earliest in the cycle after DONE, or in the cycle after aborted.

## Test plan
- NCOEFS=4, WIDTH=8. Pulse start, then stream 0x10,0x20,0x30,0x40 back-to-back → writes (0,0x10),(1,0x20),(2,0x30),(3,0x40) on consecutive cycles. done pulses with the last write, coef_sum=0xA0, then busy=0.
- Same burst with in_valid low for 2 cycles between beats 1 and 2 → coef_we is low in the gap cycles, addresses stay contiguous 0..3, and there is a single done pulse.
- Start, accept 0xFF, 0xFF, then assert abort with in_valid=1 → in_ready=0 that cycle, aborted pulses, no done, and only addresses 0–1 are written. coef_sum=0x1FE is held. A subsequent start clears coef_sum to 0.
- Hold in_valid=1 with data 0x01 for 10 cycles after start → exactly 4 beats are accepted. in_ready=0 during DONE/IDLE, and coef_sum=4.
- Pulse start during LOAD, and again during the DONE cycle → no effect; the counter and addresses are unaffected.
- Assert nreset=0 after 2 of 4 beats → next cycle all outputs are 0 and the state is IDLE. A new start then loads from address 0 normally.
